exp_rom_loader: RTL

Parametrised download-to-SDRAM loader for system and expansion ROM images, the successor to the inline boot/rom_map logic in the CPC top level.
- Accepts the hps_io ioctl byte stream, holds ioctl_wait while each byte is written into one or more SDRAM banks in ce_ref slots, and records which 16 KB upper-ROM pages hold valid data.
- New behaviour: N-bank mirroring, generic hex/lowercase extension parsing, a registered page-map query port and a map-clear command.

---
 rtl/cpc_rom_pkg.sv | 39 +++
 rtl/rom_page_map.sv | 24 ++
 rtl/exp_rom_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpc_rom_pkg.sv
// Shared types and helpers for the CPC ROM download path: FSM states,
// the fixed system-image page table and ASCII hex decoding.
package cpc_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WRITE
  } state_t;

  // System image 16 KB segments map to {rom_flag, page}
  localparam logic [8:0] SYS_PAGE_0 = 9'h000;
  localparam logic [8:0] SYS_PAGE_1 = 9'h100;
  localparam logic [8:0] SYS_PAGE_2 = 9'h107;
  localparam logic [8:0] SYS_PAGE_3 = 9'h1FF;

  localparam logic [7:0] CH_Z    = 8'h5A;
  localparam logic [7:0] CH_ZERO = 8'h30;

  function automatic logic [8:0] sys_page(input logic [1:0] sel);
    case (sel)
      2'd0:    return SYS_PAGE_0;
      2'd1:    return SYS_PAGE_1;
      2'd2:    return SYS_PAGE_2;
      default: return SYS_PAGE_3;
    endcase
  endfunction

  // Returns {valid, nibble}; accepts 0-9, A-F, a-f
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0_0000;
  endfunction

endpackage

// File: rtl/rom_page_map.sv
// One valid bit per upper-ROM page; clear beats set, reads return the
// contents before the same-edge update.
module rom_page_map #(
  parameter int PAGE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic              i_set,
  input  logic [PAGE_W-1:0] i_set_page,
  input  logic [PAGE_W-1:0] i_rd_page,
  output logic              o_hit
);

  logic [2**PAGE_W-1:0] r_map;

  always_ff @(posedge i_clk) begin
    o_hit <= r_map[i_rd_page];
    if (i_clear)
      r_map <= '0;
    else if (i_set)
      r_map[i_set_page] <= 1'b1;
  end

endmodule

// File: rtl/exp_rom_loader.sv
// Streams hps_io download bytes into SDRAM banks one ce_ref slot pair per
// bank write, and tracks which upper-ROM pages have been loaded.
module exp_rom_loader
  import cpc_rom_pkg::*;
#(
  parameter int              BANKS    = 2,
  parameter int              PAGE_W   = 8,
  parameter int              ADDR_W   = 23,
  parameter logic [PAGE_W-1:0] BAD_PAGE = 8'hEE,
  parameter int              BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_ref,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic [15:0]       ioctl_file_ext,
  output logic              ioctl_wait,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [7:0]        mem_din,
  input  logic [PAGE_W-1:0] map_page,
  output logic              map_hit,
  input  logic              map_clear
);

  state_t            r_state;
  logic              r_dl_q;
  logic              r_rom_flag;
  logic [PAGE_W-1:0] r_page;
  logic [PAGE_W-1:0] r_seg_sub;
  logic              r_combo;
  logic              r_mirror;
  logic [PAGE_W-1:0] r_src_pg;

  logic              w_dl_rise;
  logic [4:0]        w_nib_hi;
  logic [4:0]        w_nib_lo;
  logic              w_ext_flag;
  logic [PAGE_W-1:0] w_ext_page;
  logic              w_ext_combo;
  logic [10:0]       w_seg;
  logic [8:0]        w_sys;
  logic              w_sys_ok;
  logic [BANK_W-1:0] w_sys_bank;
  logic [PAGE_W-1:0] w_src_pg;
  logic [PAGE_W-1:0] w_exp_pg;
  logic [ADDR_W-1:0] w_addr;
  logic              w_accept;
  logic              w_next_bank;
  logic              w_map_set;

  always_ff @(posedge clk_sys) begin
    r_dl_q <= ioctl_download;
  end

  assign w_dl_rise = ioctl_download & ~r_dl_q;
  assign w_nib_hi  = hex_nib(ioctl_file_ext[15:8]);
  assign w_nib_lo  = hex_nib(ioctl_file_ext[7:0]);

  always_comb begin
    w_ext_flag  = 1'b1;
    w_ext_page  = BAD_PAGE;
    w_ext_combo = 1'b0;
    if (ioctl_file_ext[15:8] == CH_Z && ioctl_file_ext[7:0] == CH_Z) begin
      w_ext_flag = 1'b0;
      w_ext_page = '0;
    end else if (ioctl_file_ext[15:8] == CH_Z && ioctl_file_ext[7:0] == CH_ZERO) begin
      w_ext_flag  = 1'b0;
      w_ext_page  = '0;
      w_ext_combo = 1'b1;
    end else if (w_nib_hi[4] && w_nib_lo[4]) begin
      w_ext_page = PAGE_W'({w_nib_hi[3:0], w_nib_lo[3:0]});
    end
  end

  assign w_seg      = ioctl_addr[24:14];
  assign w_sys      = sys_page(w_seg[1:0]);
  assign w_sys_ok   = ({21'd0, w_seg} < 32'(4 * BANKS));
  assign w_sys_bank = BANK_W'(w_seg >> 2);
  assign w_src_pg   = ioctl_addr[PAGE_W+13:14];
  // r_seg_sub rebases the file so the segment after a combo switch lands on page '1
  assign w_exp_pg   = r_page + w_src_pg - r_seg_sub;
  assign w_accept   = (ioctl_index != 8'd0) | w_sys_ok;

  always_comb begin
    if (ioctl_index == 8'd0)
      w_addr = {w_sys[8], PAGE_W'(w_sys[7:0]), ioctl_addr[13:0]};
    else
      w_addr = {r_rom_flag, w_exp_pg, ioctl_addr[13:0]};
  end

  assign w_next_bank = r_mirror && (mem_bank != BANK_W'(BANKS - 1));
  assign w_map_set   = (r_state == ST_WRITE) && ce_ref && !w_next_bank &&
                       mem_addr[ADDR_W-1] && !reset;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      ioctl_wait <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_bank   <= '0;
      mem_din    <= '0;
      r_rom_flag <= 1'b1;
      r_page     <= BAD_PAGE;
      r_combo    <= 1'b0;
      r_seg_sub  <= '0;
      r_mirror   <= 1'b0;
      r_src_pg   <= '0;
    end else begin
      if (w_dl_rise && ioctl_index != 8'd0) begin
        r_rom_flag <= w_ext_flag;
        r_page     <= w_ext_page;
        r_combo    <= w_ext_combo;
        r_seg_sub  <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (ioctl_download && ioctl_wr && w_accept) begin
            mem_addr   <= w_addr;
            mem_bank   <= (ioctl_index == 8'd0) ? w_sys_bank : '0;
            mem_din    <= ioctl_dout;
            r_mirror   <= (ioctl_index != 8'd0);
            r_src_pg   <= w_src_pg;
            ioctl_wait <= 1'b1;
            r_state    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (ce_ref) begin
            mem_wr  <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (ce_ref) begin
            mem_wr <= 1'b0;
            if (w_next_bank) begin
              mem_bank <= mem_bank + 1'b1;
              r_state  <= ST_ARM;
            end else begin
              r_state    <= ST_IDLE;
              ioctl_wait <= 1'b0;
              if (r_combo && mem_addr[13:0] == 14'h3FFF) begin
                r_rom_flag <= 1'b1;
                r_page     <= '1;
                r_combo    <= 1'b0;
                r_seg_sub  <= r_src_pg + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rom_page_map #(
    .PAGE_W(PAGE_W)
  ) u_map (
    .i_clk      (clk_sys),
    .i_clear    (map_clear),
    .i_set      (w_map_set),
    .i_set_page (mem_addr[ADDR_W-2 -: PAGE_W]),
    .i_rd_page  (map_page),
    .o_hit      (map_hit)
  );

endmodule
